// File: rtl/result_dispatcher_if.sv
// result_dispatcher_if
//   Bundles the result-FIFO read port and both master delivery ports.
//   master : the dispatcher side (pops the FIFO, drives both masters)
//   slave  : the environment side (FIFO and the two masters)
//   Signals:
//     fifo_empty / fifo_rd_en / fifo_rd_data / fifo_rd_mode / fifo_rd_proc_val
//     mstrK_data / mstrK_mode / mstrK_proc_val / mstrK_data_valid / mstrK_ready / mstrK_cmplt
//     drop_cnt : saturating count of words discarded for an illegal mode
interface result_dispatcher_if #(
    parameter int DW = 32
);
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic [1:0]    fifo_rd_mode;
    logic [7:0]    fifo_rd_proc_val;

    logic [DW-1:0] mstr0_data;
    logic [1:0]    mstr0_mode;
    logic [7:0]    mstr0_proc_val;
    logic          mstr0_data_valid;
    logic          mstr0_ready;
    logic          mstr0_cmplt;

    logic [DW-1:0] mstr1_data;
    logic [1:0]    mstr1_mode;
    logic [7:0]    mstr1_proc_val;
    logic          mstr1_data_valid;
    logic          mstr1_ready;
    logic          mstr1_cmplt;

    logic [7:0]    drop_cnt;

    modport master (
        input  fifo_empty, fifo_rd_data, fifo_rd_mode, fifo_rd_proc_val,
        input  mstr0_ready, mstr1_ready,
        output fifo_rd_en,
        output mstr0_data, mstr0_mode, mstr0_proc_val, mstr0_data_valid, mstr0_cmplt,
        output mstr1_data, mstr1_mode, mstr1_proc_val, mstr1_data_valid, mstr1_cmplt,
        output drop_cnt
    );

    modport slave (
        output fifo_empty, fifo_rd_data, fifo_rd_mode, fifo_rd_proc_val,
        output mstr0_ready, mstr1_ready,
        input  fifo_rd_en,
        input  mstr0_data, mstr0_mode, mstr0_proc_val, mstr0_data_valid, mstr0_cmplt,
        input  mstr1_data, mstr1_mode, mstr1_proc_val, mstr1_data_valid, mstr1_cmplt,
        input  drop_cnt
    );
endinterface

// File: rtl/result_dispatcher.sv
// result_dispatcher
//   Pops processed words from the shared result FIFO and routes each one to
//   master 0 (mode 01) or master 1 (mode 10) over a valid/ready handshake.
//   Illegal modes (00/11) are discarded and counted in drop_cnt (saturating).
//   Per-master beat counters pulse mstrK_cmplt for one cycle after every
//   FRAME_LEN-th accepted beat.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : result_dispatcher_if.master (FIFO read port + both master ports)
module result_dispatcher #(
    parameter int DW        = 32,
    parameter int FRAME_LEN = 64,
    parameter int CW        = 16
) (
    input  logic                clk,
    input  logic                rst,
    result_dispatcher_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

    state_t        state, state_nxt;
    logic          dest;        // 0: master 0 owns the held word, 1: master 1
    logic          accept;
    logic          rd_en;
    logic          mode_legal;

    logic [DW-1:0] data0, data1;
    logic [1:0]    mode0, mode1;
    logic [7:0]    pv0, pv1;
    logic          valid0, valid1;
    logic          cmplt0, cmplt1;
    logic [CW-1:0] cnt0, cnt1;
    logic [7:0]    drop_cnt;

    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

    assign mode_legal = (bus.fifo_rd_mode == 2'b01) || (bus.fifo_rd_mode == 2'b10);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_en) state_nxt = FETCH;
            FETCH:   state_nxt = mode_legal ? DELIVER : IDLE;
            DELIVER: if (accept) state_nxt = rd_en ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    // Only the selected master's ready participates; the other is ignored.
    // rd_en is masked during reset so nothing is popped while state is held.
    always_comb begin
        accept = 1'b0;
        rd_en  = 1'b0;
        if (state == DELIVER)
            accept = dest ? (valid1 && bus.mstr1_ready) : (valid0 && bus.mstr0_ready);
        if (!rst && !bus.fifo_empty)
            rd_en = (state == IDLE) || (state == DELIVER && accept);
    end

    // ---------------- datapath ----------------
    // FETCH and DELIVER are exclusive, so a load and an accept never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            dest     <= 1'b0;
            data0    <= '0;  mode0 <= '0;  pv0 <= '0;  valid0 <= 1'b0;
            data1    <= '0;  mode1 <= '0;  pv1 <= '0;  valid1 <= 1'b0;
            cmplt0   <= 1'b0;
            cmplt1   <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
            drop_cnt <= '0;
        end else begin
            cmplt0 <= 1'b0;
            cmplt1 <= 1'b0;

            if (accept) begin
                if (dest) begin
                    valid1 <= 1'b0;
                    if (cnt1 == LAST_BEAT) begin
                        cnt1   <= '0;
                        cmplt1 <= 1'b1;
                    end else begin
                        cnt1 <= cnt1 + 1'b1;
                    end
                end else begin
                    valid0 <= 1'b0;
                    if (cnt0 == LAST_BEAT) begin
                        cnt0   <= '0;
                        cmplt0 <= 1'b1;
                    end else begin
                        cnt0 <= cnt0 + 1'b1;
                    end
                end
            end

            if (state == FETCH) begin
                case (bus.fifo_rd_mode)
                    2'b01: begin
                        data0  <= bus.fifo_rd_data;
                        mode0  <= bus.fifo_rd_mode;
                        pv0    <= bus.fifo_rd_proc_val;
                        valid0 <= 1'b1;
                        dest   <= 1'b0;
                    end
                    2'b10: begin
                        data1  <= bus.fifo_rd_data;
                        mode1  <= bus.fifo_rd_mode;
                        pv1    <= bus.fifo_rd_proc_val;
                        valid1 <= 1'b1;
                        dest   <= 1'b1;
                    end
                    default: if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                endcase
            end
        end
    end

    assign bus.fifo_rd_en       = rd_en;
    assign bus.mstr0_data       = data0;
    assign bus.mstr0_mode       = mode0;
    assign bus.mstr0_proc_val   = pv0;
    assign bus.mstr0_data_valid = valid0;
    assign bus.mstr0_cmplt      = cmplt0;
    assign bus.mstr1_data       = data1;
    assign bus.mstr1_mode       = mode1;
    assign bus.mstr1_proc_val   = pv1;
    assign bus.mstr1_data_valid = valid1;
    assign bus.mstr1_cmplt      = cmplt1;
    assign bus.drop_cnt         = drop_cnt;

endmodule

// File: tb/tb_result_dispatcher.sv
module tb_result_dispatcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_dispatcher_if #(.DW(32)) bus();

    result_dispatcher #(.DW(32), .FRAME_LEN(4), .CW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- FIFO model: data appears the cycle after rd_en ----------------
    logic [31:0] md [0:1023];
    logic [1:0]  mm [0:1023];
    logic [7:0]  mp [0:1023];
    int wp = 0;
    int rp = 0;

    assign bus.fifo_empty = (wp == rp);

    initial begin
        bus.fifo_rd_data     = '0;
        bus.fifo_rd_mode     = '0;
        bus.fifo_rd_proc_val = '0;
    end

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data     <= md[rp];
            bus.fifo_rd_mode     <= mm[rp];
            bus.fifo_rd_proc_val <= mp[rp];
            rp <= rp + 1;
        end
    end

    // ---------------- monitor ----------------
    int acc0 = 0, acc1 = 0, pul0 = 0, pul1 = 0, both_v = 0, both_c = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.mstr0_data_valid && bus.mstr0_ready) acc0 <= acc0 + 1;
            if (bus.mstr1_data_valid && bus.mstr1_ready) acc1 <= acc1 + 1;
            if (bus.mstr0_cmplt) pul0 <= pul0 + 1;
            if (bus.mstr1_cmplt) pul1 <= pul1 + 1;
            if (bus.mstr0_data_valid && bus.mstr1_data_valid) both_v <= both_v + 1;
            if (bus.mstr0_cmplt && bus.mstr1_cmplt) both_c <= both_c + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] m, input logic [7:0] p);
        md[wp] = d;
        mm[wp] = m;
        mp[wp] = p;
        wp = wp + 1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        logic [7:0]  p;
        logic [1:0]  dst;   // {master1 seen, master0 seen}
        logic [7:0]  drop;  // absolute drop_cnt after the word
        int          c0;    // mstr0_cmplt pulses caused by this word
        int          c1;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] gd;
        logic [7:0]  gp;
        logic [1:0]  gm;
        bit          ok, s0, s1;
        int          a, p0, p1;

        tbl[0]  = '{32'hA000_0000, 2'b00, 8'h10, 2'b00, 8'd1, 0, 0};
        tbl[1]  = '{32'hA000_0001, 2'b11, 8'h11, 2'b00, 8'd2, 0, 0};
        tbl[2]  = '{32'hA000_0002, 2'b00, 8'h12, 2'b00, 8'd3, 0, 0};
        tbl[3]  = '{32'hA000_0003, 2'b01, 8'h13, 2'b01, 8'd3, 0, 0};
        tbl[4]  = '{32'hA000_0004, 2'b01, 8'h14, 2'b01, 8'd3, 0, 0};
        tbl[5]  = '{32'hA000_0005, 2'b01, 8'h15, 2'b01, 8'd3, 0, 0};
        tbl[6]  = '{32'hA000_0006, 2'b01, 8'h16, 2'b01, 8'd3, 1, 0};
        tbl[7]  = '{32'hB000_0007, 2'b10, 8'h27, 2'b10, 8'd3, 0, 0};
        tbl[8]  = '{32'hB000_0008, 2'b10, 8'h28, 2'b10, 8'd3, 0, 0};
        tbl[9]  = '{32'hB000_0009, 2'b10, 8'h29, 2'b10, 8'd3, 0, 0};
        tbl[10] = '{32'hB000_000A, 2'b10, 8'h2A, 2'b10, 8'd3, 0, 1};
        tbl[11] = '{32'hA000_000B, 2'b01, 8'h1B, 2'b01, 8'd3, 0, 0};
        tbl[12] = '{32'hC000_000C, 2'b11, 8'h3C, 2'b00, 8'd4, 0, 0};

        bus.mstr0_ready = 1'b1;
        bus.mstr1_ready = 1'b0;

        // ---- reset with a preloaded word: no pop while rst is high ----
        push(32'hDEADBEEF, 2'b01, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
        end
        chk("rst_valid0", bus.mstr0_data_valid, 1'b0);
        chk("rst_valid1", bus.mstr1_data_valid, 1'b0);
        chk("rst_data0",  bus.mstr0_data, 32'h0);
        chk("rst_cmplt",  {bus.mstr0_cmplt, bus.mstr1_cmplt}, 2'b00);
        chk("rst_drop",   bus.drop_cnt, 8'd0);

        // ---- latency: rd_en at N, valid at N+2 ----
        rst = 1'b0;
        #1;
        chk("lat_rd_en_N", bus.fifo_rd_en, 1'b1);
        @(negedge clk);
        chk("lat_valid_N1", bus.mstr0_data_valid, 1'b0);
        @(negedge clk);
        chk("lat_valid_N2", bus.mstr0_data_valid, 1'b1);
        chk("lat_data",     bus.mstr0_data, 32'hDEADBEEF);
        chk("lat_pv",       bus.mstr0_proc_val, 8'h5A);
        chk("lat_mode",     bus.mstr0_mode, 2'b01);
        chk("lat_valid1",   bus.mstr1_data_valid, 1'b0);
        @(negedge clk);
        chk("lat_deassert", bus.mstr0_data_valid, 1'b0);
        repeat (2) @(negedge clk);

        // ---- backpressure on master 1 ----
        do_reset(2);
        a = acc1;
        push(32'h12345678, 2'b10, 8'h33);
        push(32'hCAFEF00D, 2'b10, 8'h44);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (bus.mstr1_data_valid) ok = 1;
        end
        chk("bp_wait_valid", ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.mstr1_data_valid, 1'b1);
            chk("bp_hold_data",  bus.mstr1_data, 32'h12345678);
            chk("bp_hold_pv",    bus.mstr1_proc_val, 8'h33);
            chk("bp_no_pop",     bus.fifo_rd_en, 1'b0);
            chk("bp_valid0",     bus.mstr0_data_valid, 1'b0);
        end
        bus.mstr1_ready = 1'b1;
        #1;
        chk("bp_pop_on_accept", bus.fifo_rd_en, 1'b1);
        @(negedge clk);
        chk("bp_one_accept", acc1 - a, 1);
        chk("bp_fetch_gap",  bus.mstr1_data_valid, 1'b0);
        @(negedge clk);
        chk("bp_second_valid", bus.mstr1_data_valid, 1'b1);
        chk("bp_second_data",  bus.mstr1_data, 32'hCAFEF00D);
        @(negedge clk);
        chk("bp_two_accepts", acc1 - a, 2);

        // ---- table: illegal modes, routing, frame completion ----
        do_reset(2);
        foreach (tbl[k]) begin
            push(tbl[k].d, tbl[k].m, tbl[k].p);
            s0 = 0; s1 = 0; gd = '0; gp = '0; gm = '0;
            p0 = pul0; p1 = pul1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.mstr0_data_valid && !s0) begin
                    s0 = 1; gd = bus.mstr0_data; gp = bus.mstr0_proc_val; gm = bus.mstr0_mode;
                end
                if (bus.mstr1_data_valid && !s1) begin
                    s1 = 1; gd = bus.mstr1_data; gp = bus.mstr1_proc_val; gm = bus.mstr1_mode;
                end
            end
            chk($sformatf("tbl%0d_dest", k), {s1, s0}, tbl[k].dst);
            if (tbl[k].dst != 2'b00) begin
                chk($sformatf("tbl%0d_data", k), {gd, gp, gm}, {tbl[k].d, tbl[k].p, tbl[k].m});
            end
            chk($sformatf("tbl%0d_drop", k), bus.drop_cnt, tbl[k].drop);
            chk($sformatf("tbl%0d_cmplt0", k), pul0 - p0, tbl[k].c0);
            chk($sformatf("tbl%0d_cmplt1", k), pul1 - p1, tbl[k].c1);
        end

        // ---- drop counter saturation: 4 + 260 drops ----
        a = acc0 + acc1;
        for (int i = 0; i < 260; i++) push(32'(i), (i % 2 == 0) ? 2'b00 : 2'b11, 8'h00);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.fifo_empty) ok = 1;
        end
        chk("sat_drain", ok, 1'b1);
        repeat (4) @(negedge clk);
        chk("sat_drop", bus.drop_cnt, 8'd255);
        chk("sat_no_delivery", acc0 + acc1 - a, 0);

        // ---- mid-frame reset ----
        do_reset(2);
        a  = acc0;
        p0 = pul0;
        push(32'hD000_0001, 2'b01, 8'h01);
        push(32'hD000_0002, 2'b01, 8'h02);
        repeat (10) @(negedge clk);
        chk("mf_pre_accepts", acc0 - a, 2);
        do_reset(1);
        for (int k = 1; k <= 4; k++) begin
            push(32'hE000_0000 + 32'(k), 2'b01, 8'(k));
            repeat (6) @(negedge clk);
            chk($sformatf("mf_post%0d_cmplt0", k), pul0 - p0, (k == 4) ? 1 : 0);
        end
        chk("mf_accepts", acc0 - a, 6);

        chk("never_both_valid", both_v, 0);
        chk("never_both_cmplt", both_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
